// File: rtl/igbt_pkg.sv
// Shared state encoding, fault codes and default shot timing for the
// IGBT/SCR pulse sequencer.
package igbt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHARGE    = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_FIRE_IGBT = 3'd3,
    ST_DEAD      = 3'd4,
    ST_FIRE_SCR  = 3'd5,
    ST_COOLDOWN  = 3'd6,
    ST_FAULT     = 3'd7
  } state_e;

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_TIMEOUT  = 2'd1;
  localparam logic [1:0] FC_ABORT    = 2'd2;
  localparam logic [1:0] FC_OVERVOLT = 2'd3;

  localparam int DEF_CHARGE_TIMEOUT    = 5_000_000;
  localparam int DEF_SETTLE_CYCLES     = 500;
  localparam int DEF_IGBT_PULSE_CYCLES = 250;
  localparam int DEF_DEAD_CYCLES       = 50;
  localparam int DEF_SCR_PULSE_CYCLES  = 100;
  localparam int DEF_COOLDOWN_CYCLES   = 50_000;
  localparam int DEF_OV_LIMIT_MV       = 26000;

  // A zero-length phase would never terminate its counter compare.
  function automatic int at_least_one(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/igbt_pulse_sequencer_gate_interlock.sv
// Registered output stage for the gate drivers: enforces IGBT/SCR/charger
// mutual exclusion and forces everything off on abort, independent of the FSM.
module gate_interlock (
  input  logic clk,
  input  logic rst,
  input  logic force_off_i,
  input  logic charge_req_i,
  input  logic igbt_req_i,
  input  logic scr_req_i,
  output logic charge_en_o,
  output logic igbt_gate_o,
  output logic scr_trig_o
);

  logic charge_en_q;
  logic igbt_gate_q;
  logic scr_trig_q;

  // Conflicting requests drop both gates rather than pick a winner.
  always_ff @(posedge clk) begin
    if (rst || force_off_i) begin
      charge_en_q <= 1'b0;
      igbt_gate_q <= 1'b0;
      scr_trig_q  <= 1'b0;
    end else begin
      igbt_gate_q <= igbt_req_i & ~scr_req_i;
      scr_trig_q  <= scr_req_i & ~igbt_req_i;
      charge_en_q <= charge_req_i & ~igbt_req_i & ~scr_req_i;
    end
  end

  assign charge_en_o = charge_en_q;
  assign igbt_gate_o = igbt_gate_q;
  assign scr_trig_o  = scr_trig_q;

endmodule

// File: rtl/igbt_pulse_sequencer.sv
// Single-shot pulse-power sequencer: charge, qualify, settle, IGBT, dead, SCR,
// cooldown. Define OVERVOLT_TRIP_EN to enable the cap_mv overvoltage trip.
module igbt_pulse_sequencer
  import igbt_pkg::*;
#(
  parameter int CHARGE_TIMEOUT    = DEF_CHARGE_TIMEOUT,
  parameter int SETTLE_CYCLES     = DEF_SETTLE_CYCLES,
  parameter int IGBT_PULSE_CYCLES = DEF_IGBT_PULSE_CYCLES,
  parameter int DEAD_CYCLES       = DEF_DEAD_CYCLES,
  parameter int SCR_PULSE_CYCLES  = DEF_SCR_PULSE_CYCLES,
  parameter int COOLDOWN_CYCLES   = DEF_COOLDOWN_CYCLES,
  parameter int OV_LIMIT_MV       = DEF_OV_LIMIT_MV
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               shot_start,
  input  logic               shot_abort,
  input  logic [2:0]         cap_mask,
  input  logic [2:0]         voltage_cap_flag,
  input  logic signed [31:0] cap_mv_1,
  input  logic signed [31:0] cap_mv_2,
  output logic               charge_en,
  output logic               igbt_gate,
  output logic               scr_trig,
  output logic               busy,
  output logic               shot_done,
  output logic               fault,
  output logic [1:0]         fault_code
);

  localparam int TO_EFF   = at_least_one(CHARGE_TIMEOUT);
  localparam int SET_EFF  = at_least_one(SETTLE_CYCLES);
  localparam int IGBT_EFF = at_least_one(IGBT_PULSE_CYCLES);
  localparam int DEAD_EFF = at_least_one(DEAD_CYCLES);
  localparam int SCR_EFF  = at_least_one(SCR_PULSE_CYCLES);
  localparam int COOL_EFF = at_least_one(COOLDOWN_CYCLES);
  localparam int MAX_P    = max2(max2(max2(TO_EFF, SET_EFF), max2(IGBT_EFF, DEAD_EFF)),
                                 max2(SCR_EFF, COOL_EFF));
  localparam int CW       = (MAX_P > 1) ? $clog2(MAX_P) : 1;

  localparam logic [CW-1:0] TO_LAST   = CW'(TO_EFF - 1);
  localparam logic [CW-1:0] SET_LAST  = CW'(SET_EFF - 1);
  localparam logic [CW-1:0] IGBT_LAST = CW'(IGBT_EFF - 1);
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_EFF - 1);
  localparam logic [CW-1:0] SCR_LAST  = CW'(SCR_EFF - 1);
  localparam logic [CW-1:0] COOL_LAST = CW'(COOL_EFF - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    code_q, code_d;
  logic          busy_q, done_q, fault_q;
  logic          ready_s, ov_trip_s, force_off_s;

  assign ready_s     = ((voltage_cap_flag & cap_mask) == cap_mask);
  assign force_off_s = shot_abort && (state_q != ST_IDLE);

`ifdef OVERVOLT_TRIP_EN
  assign ov_trip_s = (state_q inside {ST_CHARGE, ST_SETTLE, ST_FIRE_IGBT, ST_DEAD, ST_FIRE_SCR})
                     && ((cap_mv_1 > OV_LIMIT_MV) || (cap_mv_2 > OV_LIMIT_MV));
`else
  logic unused_mv_s;
  assign unused_mv_s = ^{cap_mv_1, cap_mv_2};
  assign ov_trip_s   = 1'b0;
`endif

  // Next-state: abort beats overvoltage beats the per-state progression.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    if (force_off_s) begin
      state_d = ST_FAULT;
      cnt_d   = '0;
      code_d  = FC_ABORT;
    end else if (ov_trip_s) begin
      state_d = ST_FAULT;
      cnt_d   = '0;
      code_d  = FC_OVERVOLT;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (shot_start) begin
            state_d = ST_CHARGE;
            cnt_d   = '0;
          end else begin
            cnt_d = '0;
          end
        end
        ST_CHARGE: begin
          if (ready_s) begin
            state_d = ST_SETTLE;
            cnt_d   = '0;
          end else if (cnt_q == TO_LAST) begin
            state_d = ST_FAULT;
            cnt_d   = '0;
            code_d  = FC_TIMEOUT;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_SETTLE: begin
          if (!ready_s) begin
            state_d = ST_CHARGE;
            cnt_d   = '0;
          end else if (cnt_q == SET_LAST) begin
            state_d = ST_FIRE_IGBT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_FIRE_IGBT: begin
          if (cnt_q == IGBT_LAST) begin
            state_d = ST_DEAD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_DEAD: begin
          if (cnt_q == DEAD_LAST) begin
            state_d = ST_FIRE_SCR;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_FIRE_SCR: begin
          if (cnt_q == SCR_LAST) begin
            state_d = ST_COOLDOWN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_COOLDOWN: begin
          if (cnt_q == COOL_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_FAULT: begin
          if (shot_start) begin
            state_d = ST_IDLE;
            code_d  = FC_NONE;
          end else begin
            state_d = ST_FAULT;
          end
        end
        default: begin
          state_d = ST_FAULT;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // FSM state and registered status outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      code_q  <= FC_NONE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      busy_q  <= !(state_d inside {ST_IDLE, ST_FAULT});
      done_q  <= (state_q == ST_COOLDOWN) && (state_d == ST_IDLE);
      fault_q <= (state_d == ST_FAULT);
    end
  end

  gate_interlock u_gate_interlock (
    .clk          (sys_clk),
    .rst          (sys_rst),
    .force_off_i  (force_off_s),
    .charge_req_i (state_d inside {ST_CHARGE, ST_SETTLE}),
    .igbt_req_i   (state_d == ST_FIRE_IGBT),
    .scr_req_i    (state_d == ST_FIRE_SCR),
    .charge_en_o  (charge_en),
    .igbt_gate_o  (igbt_gate),
    .scr_trig_o   (scr_trig)
  );

  assign busy       = busy_q;
  assign shot_done  = done_q;
  assign fault      = fault_q;
  assign fault_code = code_q;

endmodule

// File: tb/tb_igbt_pulse_sequencer.sv
// Self-checking bench for igbt_pulse_sequencer: phase-timeline model compared
// every cycle, plus directed literal checks. Honours OVERVOLT_TRIP_EN.
module tb_igbt_pulse_sequencer;

  localparam int T_TO = 20, T_SET = 4, T_IGBT = 3, T_DEAD = 2, T_SCR = 2, T_COOL = 5;
  localparam int OV_LIM = 26000;
`ifdef OVERVOLT_TRIP_EN
  localparam bit OV_EN = 1'b1;
`else
  localparam bit OV_EN = 1'b0;
`endif

  logic sys_clk = 1'b0, sys_rst = 1'b1, shot_start = 1'b0, shot_abort = 1'b0;
  logic [2:0] cap_mask = 3'b000, voltage_cap_flag = 3'b000;
  logic signed [31:0] cap_mv_1 = 32'sd0, cap_mv_2 = 32'sd0;
  logic charge_en, igbt_gate, scr_trig, busy, shot_done, fault;
  logic [1:0] fault_code;

  igbt_pulse_sequencer #(
    .CHARGE_TIMEOUT(T_TO), .SETTLE_CYCLES(T_SET), .IGBT_PULSE_CYCLES(T_IGBT),
    .DEAD_CYCLES(T_DEAD), .SCR_PULSE_CYCLES(T_SCR), .COOLDOWN_CYCLES(T_COOL),
    .OV_LIMIT_MV(OV_LIM)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .shot_start(shot_start), .shot_abort(shot_abort),
    .cap_mask(cap_mask), .voltage_cap_flag(voltage_cap_flag),
    .cap_mv_1(cap_mv_1), .cap_mv_2(cap_mv_2),
    .charge_en(charge_en), .igbt_gate(igbt_gate), .scr_trig(scr_trig), .busy(busy),
    .shot_done(shot_done), .fault(fault), .fault_code(fault_code)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0, n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: a named phase plus cycles spent in it; timed phases use a duration table.
  string ph = "idle";
  int el = 0, mcode = 0;
  bit mdone = 1'b0;

  function automatic int dur(input string p);
    if (p == "igbt") return T_IGBT;
    else if (p == "dead") return T_DEAD;
    else if (p == "scr") return T_SCR;
    else return T_COOL;
  endfunction

  function automatic string after(input string p);
    if (p == "igbt") return "dead";
    else if (p == "dead") return "scr";
    else if (p == "scr") return "cool";
    else return "idle";
  endfunction

  task automatic model_step();
    bit rdy, ov;
    rdy = ((voltage_cap_flag & cap_mask) == cap_mask);
    ov = OV_EN && (ph == "charge" || ph == "settle" || ph == "igbt" || ph == "dead" || ph == "scr")
         && (cap_mv_1 > OV_LIM || cap_mv_2 > OV_LIM);
    mdone = 1'b0;
    if (sys_rst) begin ph = "idle"; el = 0; mcode = 0; end
    else if (ph != "idle" && shot_abort) begin ph = "fault"; mcode = 2; end
    else if (ov) begin ph = "fault"; mcode = 3; end
    else if (ph == "idle") begin
      if (shot_start) begin ph = "charge"; el = 0; end
    end else if (ph == "charge") begin
      if (rdy) begin ph = "settle"; el = 0; end
      else if (el + 1 >= T_TO) begin ph = "fault"; mcode = 1; end
      else el++;
    end else if (ph == "settle") begin
      if (!rdy) begin ph = "charge"; el = 0; end
      else if (el + 1 >= T_SET) begin ph = "igbt"; el = 0; end
      else el++;
    end else if (ph == "fault") begin
      if (shot_start) begin ph = "idle"; mcode = 0; end
    end else begin
      el++;
      if (el >= dur(ph)) begin
        if (ph == "cool") mdone = 1'b1;
        ph = after(ph);
        el = 0;
      end
    end
  endtask

  // Per-cycle comparison against the model and the gate interlock rules.
  always @(negedge sys_clk) begin
    if (chk_en) begin
      chk("charge_en", charge_en, (ph == "charge" || ph == "settle"));
      chk("igbt_gate", igbt_gate, (ph == "igbt"));
      chk("scr_trig", scr_trig, (ph == "scr"));
      chk("busy", busy, !(ph == "idle" || ph == "fault"));
      chk("shot_done", shot_done, mdone);
      chk("fault", fault, (ph == "fault"));
      chk("fault_code", fault_code, mcode);
      chk("ilk_igbt_scr", igbt_gate & scr_trig, 0);
      chk("ilk_charge_gate", charge_en & (igbt_gate | scr_trig), 0);
    end
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
    model_step();
  endtask

  task automatic run_shot(input int flag_at, input int drop_at, input int abort_at,
                          input int mv_at, input logic signed [31:0] mv_val, input int ncyc,
                          output int ig_first, output int ig_cnt, output int scr_first,
                          output int scr_cnt, output int done_at, output int fault_at);
    ig_first = -1; ig_cnt = 0; scr_first = -1; scr_cnt = 0; done_at = -1; fault_at = -1;
    for (int i = 0; i < ncyc; i++) begin
      shot_start = (i == 0);
      voltage_cap_flag = (i >= flag_at && i != drop_at) ? 3'b011 : 3'b000;
      shot_abort = (i == abort_at);
      cap_mv_1 = (i >= mv_at) ? mv_val : 32'sd0;
      step();
      if (igbt_gate) begin ig_cnt++; if (ig_first < 0) ig_first = i; end
      if (scr_trig) begin scr_cnt++; if (scr_first < 0) scr_first = i; end
      if (shot_done && done_at < 0) done_at = i;
      if (fault && fault_at < 0) fault_at = i;
    end
    shot_start = 1'b0; shot_abort = 1'b0; voltage_cap_flag = 3'b000; cap_mv_1 = 32'sd0;
  endtask

  task automatic clear_fault();
    shot_start = 1'b1;
    step();
    shot_start = 1'b0;
    chk("clear_fault", fault, 0);
    chk("clear_code", fault_code, 0);
    step();
    chk("clear_no_start", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int igf, igc, scf, scc, dn, ft, k;
    sys_rst = 1'b1;
    step();
    chk_en = 1'b1;
    step();
    chk("rst_charge_en", charge_en, 0);
    chk("rst_igbt", igbt_gate, 0);
    chk("rst_fault", fault, 0);
    chk("rst_code", fault_code, 0);
    sys_rst = 1'b0;
    cap_mask = 3'b011;
    step();

    // Normal shot: flags arrive five cycles after start.
    run_shot(5, -1, -1, 1000, 32'sd0, 26, igf, igc, scf, scc, dn, ft);
    chk("norm_igbt_first", igf, 9);
    chk("norm_igbt_width", igc, 3);
    chk("norm_scr_first", scf, 14);
    chk("norm_scr_width", scc, 2);
    chk("norm_dead_gap", scf - (igf + igc), 2);
    chk("norm_done_at", dn, 21);
    chk("norm_no_fault", ft, -1);

    // One-cycle flag drop during SETTLE restarts qualification.
    run_shot(2, 5, -1, 1000, 32'sd0, 24, igf, igc, scf, scc, dn, ft);
    chk("glitch_igbt_first", igf, 10);
    chk("glitch_done_at", dn, 22);

    // Charge timeout, then a clearing start.
    run_shot(1000, -1, -1, 1000, 32'sd0, 22, igf, igc, scf, scc, dn, ft);
    chk("to_fault_at", ft, 20);
    chk("to_code", fault_code, 1);
    chk("to_charge_off", charge_en, 0);
    clear_fault();

    // Abort and timeout in the same cycle report abort.
    run_shot(1000, -1, 20, 1000, 32'sd0, 22, igf, igc, scf, scc, dn, ft);
    chk("abto_fault_at", ft, 20);
    chk("abto_code", fault_code, 2);
    clear_fault();

    // Abort during the IGBT pulse.
    run_shot(5, -1, 10, 1000, 32'sd0, 20, igf, igc, scf, scc, dn, ft);
    chk("abort_igbt_width", igc, 1);
    chk("abort_scr_never", scc, 0);
    chk("abort_fault_at", ft, 10);
    chk("abort_code", fault_code, 2);
    clear_fault();

    // Overvoltage one mV above the limit in SETTLE.
    run_shot(2, -1, -1, 3, 32'sd26001, 22, igf, igc, scf, scc, dn, ft);
    if (OV_EN) begin
      chk("ov_fault_at", ft, 3);
      chk("ov_code", fault_code, 3);
      clear_fault();
    end else begin
      chk("ov_off_igbt_first", igf, 6);
      chk("ov_off_done_at", dn, 18);
    end

    // Exactly at the limit never trips.
    run_shot(2, -1, -1, 3, 32'sd26000, 22, igf, igc, scf, scc, dn, ft);
    chk("ov_limit_igbt_first", igf, 6);
    chk("ov_limit_done_at", dn, 18);
    chk("ov_limit_no_fault", ft, -1);

    // Empty mask: ready is always true.
    cap_mask = 3'b000;
    run_shot(1000, -1, -1, 1000, 32'sd0, 20, igf, igc, scf, scc, dn, ft);
    chk("mask0_igbt_first", igf, 5);
    chk("mask0_done_at", dn, 17);

    // Random start/abort/flag traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) voltage_cap_flag = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 40) == 0) cap_mask = 3'($urandom_range(0, 7));
      shot_start = ($urandom_range(0, 7) == 0);
      shot_abort = ($urandom_range(0, 39) == 0);
      cap_mv_1 = ($urandom_range(0, 30) == 0) ? 32'sd26001 : 32'sd0;
      step();
    end
    shot_start = 1'b0; shot_abort = 1'b0; cap_mv_1 = 32'sd0;
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;

    // Reset in the middle of the SCR pulse.
    cap_mask = 3'b011;
    voltage_cap_flag = 3'b011;
    shot_start = 1'b1;
    step();
    shot_start = 1'b0;
    k = 0;
    while (!scr_trig && k < 40) begin
      step();
      k++;
    end
    chk("rst_scr_reached", scr_trig, 1);
    sys_rst = 1'b1;
    step();
    chk("midrst_scr", scr_trig, 0);
    chk("midrst_igbt", igbt_gate, 0);
    chk("midrst_charge", charge_en, 0);
    chk("midrst_busy", busy, 0);
    sys_rst = 1'b0;
    voltage_cap_flag = 3'b000;
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
